// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop synchronizer, 3-sample majority vote per bit,
// framing check, and a one-deep valid/ready output register.
module uart_rx #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic [2:0]           rx_state
);
    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam int PW  = $clog2(STOP_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    // Output handshake: rx_data is valid while rx_valid=1; it is consumed on any
    // rising edge where rx_valid=1 and rx_ready=1; rx_ready alone does nothing.
    state_t                 state_q, state_d;
    logic                   rx_meta_q, rx_sync_q;
    logic [DW-1:0]          div_q, div_d;
    logic [SW-1:0]          s_q, s_d;
    logic [1:0]             samp_q, samp_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [PW-1:0]          stop_q, stop_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   tick, decide, vote, complete;

    assign tick   = (div_q == DW'(DIV - 1));
    assign decide = tick && (s_q == SW'(OVERSAMPLE / 2 + 1));
    // The third sample is the live synchronized line at the decision tick.
    assign vote   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync_q) | (samp_q[1] & rx_sync_q);

    always_comb begin
        state_d     = state_q;
        div_d       = tick ? '0 : div_q + DW'(1);
        s_d         = s_q;
        samp_d      = samp_q;
        bit_d       = bit_q;
        stop_d      = stop_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        complete    = 1'b0;

        if (tick) begin
            s_d = (s_q == SW'(OVERSAMPLE - 1)) ? '0 : s_q + SW'(1);
            if (s_q == SW'(OVERSAMPLE / 2 - 1)) samp_d[0] = rx_sync_q;
            if (s_q == SW'(OVERSAMPLE / 2))     samp_d[1] = rx_sync_q;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_sync_q) begin
                    state_d = S_START;
                    s_d     = '0;
                    div_d   = '0;
                end
            end
            S_START: begin
                if (decide) begin
                    state_d = vote ? S_IDLE : S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (decide) begin
                    shift_d = (shift_q >> 1) | (DATA_BITS'(vote) << (DATA_BITS - 1));
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        state_d = S_STOP;
                        stop_d  = '0;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            S_STOP: begin
                if (decide) begin
                    if (!vote) begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end else if (stop_q == PW'(STOP_BITS - 1)) begin
                        // Re-arm at the decision point to absorb baud mismatch.
                        complete = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        stop_d = stop_q + PW'(1);
                    end
                end
            end
            S_BREAK: begin
                if (rx_sync_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (complete) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            div_q       <= '0;
            s_q         <= '0;
            samp_q      <= '0;
            bit_q       <= '0;
            stop_q      <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
            div_q       <= div_d;
            s_q         <= s_d;
            samp_q      <= samp_d;
            bit_q       <= bit_d;
            stop_q      <= stop_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign rx_state  = state_q;
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that consumes the line driven by the UART transmit stage. Idle-high, start bit, DATA_BITS data bits LSB first, STOP_BITS stop bits, no parity.
- Oversamples the line, validates the start bit, majority-votes each bit and checks framing.
- Presents each received word on a one-deep output register with a valid/ready handshake toward the consuming logic (MIPS I/O or loopback).

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD_RATE, 115200, line bit rate in baud
DATA_BITS, 8, data bits per frame
STOP_BITS, 1, stop bits checked per frame (1 or 2)
OVERSAMPLE, 16, sample ticks per bit period (even, >= 8)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
rx  input  1  asynchronous serial line, idle high
rx_data  output  DATA_BITS  received word, stable while rx_valid=1
rx_valid  output  1  rx_data holds an unconsumed word
rx_ready  input  1  consumer accepts rx_data this cycle when rx_valid=1
frame_err  output  1  one-cycle pulse: a stop bit sampled low, word discarded
overrun  output  1  one-cycle pulse: new word completed while the held word was unconsumed

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, all counters 0, rx_data=0, rx_valid=0, frame_err=0, overrun=0. Synchronizer flops preset to 1 so no false start on release.
- Synchronizer: rx passes through 2 flops before any use. All timing below is relative to the synchronized line.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer truncation; DIV >= 2 required.
  - Counter runs 0..DIV-1 and emits a 1-cycle tick at DIV-1.
  - Free-running except forced to 0 when a start edge is detected in IDLE.
  - With defaults, DIV=54 and a bit period is 864 clocks.
- Sample counter s counts ticks 0..OVERSAMPLE-1 within each bit.
- Bit value = majority of the samples at s = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1, with the decision taken at the tick s = OVERSAMPLE/2+1.
- State machine:
  - IDLE: on synchronized rx=0, go to START and clear s.
  - START: at the decision point, a voted 0 goes to DATA (bit index 0); a voted 1 is a glitch and returns to IDLE with no output.
  - DATA: at each decision point, shift the voted bit into the shift register at the current index (LSB first). After index DATA_BITS-1, go to STOP.
  - STOP: decide each of the STOP_BITS bits the same way.
    - All voted 1: frame complete; return to IDLE.
    - Any voted 0: pulse frame_err, discard the word, go to BREAK.
  - BREAK: stay until synchronized rx=1, then go to IDLE. A held-low line gives one frame_err only.
- Re-arm: IDLE is re-entered at the decision point of the last stop bit, not at its end. This tolerates about 5% clock mismatch.
- Output register and handshake:
  - Frame complete with rx_valid=0: rx_data is loaded and rx_valid=1 on the next cycle.
  - rx_valid=1 and rx_ready=1: the word is consumed and rx_valid goes 0 next cycle, unless a new word completes in that same cycle.
  - Simultaneous consume and complete: load the new word and keep rx_valid=1. This is not an overrun.
  - Complete while rx_valid=1 and rx_ready=0: pulse overrun, drop the new word, keep the old rx_data.
  - rx_ready while rx_valid=0 has no effect.
- Latency: rx_valid rises 1 clock after the last stop-bit decision tick, plus 2 clocks of synchronizer delay relative to the raw rx input.
- frame_err and overrun never assert in the same cycle as each other for the same frame.
- Mid-frame reset: aborts immediately, no output pulse. After release the receiver waits in IDLE. If rx is low at release, that is treated as a start edge.

Test Plan:
- Defaults. Send 0xA5 (8N1, 864 clk/bit), rx_ready=1 -> rx_valid pulses 1 cycle with rx_data=0xA5; no frame_err or overrun.
- Send 0x3C, 0xFF, 0x00 back-to-back, rx_ready held 0, then pulse ready 3 times -> first ready sees 0x3C; 2 overrun pulses; 0xFF and 0x00 lost; rx_valid goes 0 after the single consume.
- Drive a 300-clock low glitch on idle rx -> START rejects it, no rx_valid, receiver returns to IDLE, then correctly receives a following 0x55.
- Send 0x81 with the stop bit forced low, line returned high after 2000 clocks -> exactly one frame_err pulse, rx_valid stays 0, then a following 0x7E is received.
- Send 0x12 and 0x34 at ±3% bit-period skew (838 and 890 clk/bit) -> both words received correctly.
- Assert reset low during data bit 4 of 0xC3, release, then send 0x99 -> no output for 0xC3, all outputs 0 during reset, rx_data=0x99 received.
